// File: rtl/mem_access_unit_if.sv
// CPU-side request/response and banked data memory signals for mem_access_unit.
// slave is the unit's view; master is the CPU/memory environment's view.
interface mem_access_unit_if #(
  parameter int ADDR_W = 8
) ();
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req, we, size, sext, addr, wdata, mem_rdata,
    output rdata, busy, done, err, mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req, we, size, sext, addr, wdata, mem_rdata,
    input  rdata, busy, done, err, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit over a big-endian word-wide data memory.
// Sub-word stores are read-modify-write so the untouched bytes of the word survive.
module mem_access_unit #(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_unit_if.slave      bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t            state_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [15:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic [31:0] loadExt;
  logic [31:0] mergeWord;

  // Loaded data sits at the top of the big-endian word, so extend from the MSBs.
  always_comb begin
    loadExt = bus.mem_rdata;
    case (size_q)
      SZ_BYTE: loadExt = {{24{sext_q & bus.mem_rdata[31]}}, bus.mem_rdata[31:24]};
      SZ_HALF: loadExt = {{16{sext_q & bus.mem_rdata[31]}}, bus.mem_rdata[31:16]};
      default: loadExt = bus.mem_rdata;
    endcase
  end

  always_comb begin
    mergeWord = {wdata_q[7:0], bus.mem_rdata[23:0]};
    if (size_q == SZ_HALF) begin
      mergeWord = {wdata_q[15:0], bus.mem_rdata[15:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      sext_q      <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (bus.req) begin
            we_q    <= bus.we;
            size_q  <= bus.size;
            sext_q  <= bus.sext;
            wdata_q <= bus.wdata[15:0];
            if (bus.size == SZ_ILL) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (bus.we && bus.size == SZ_WORD) begin
              state_q     <= WR;
              busy_q      <= 1'b1;
              mem_addr_q  <= bus.addr;
              mem_wdata_q <= bus.wdata;
              mem_write_q <= 1'b1;
            end else begin
              state_q    <= RD;
              busy_q     <= 1'b1;
              mem_addr_q <= bus.addr;
              mem_read_q <= 1'b1;
            end
          end
        end
        RD: begin
          state_q <= CAP;
        end
        // mem_rdata is valid here, one cycle after the read strobe.
        CAP: begin
          if (we_q) begin
            state_q     <= WR;
            mem_wdata_q <= mergeWord;
            mem_write_q <= 1'b1;
          end else begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rdata_q <= loadExt;
          end
        end
        WR: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a big-endian byte memory model
// answering the unit's read and write strobes.
module tb_mem_access_unit;

  logic clk;
  logic rst;

  mem_access_unit_if #(.ADDR_W(8)) bus ();

  mem_access_unit #(.ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:255];

  int assertCount = 0;
  int failCount   = 0;
  int readCount   = 0;
  int writeCount  = 0;
  int bothCount   = 0;
  logic [7:0]  lastRaddr;
  logic [7:0]  lastWaddr;
  logic [31:0] lastWdata;
  int          lat;
  logic        doneErr;

  // Memory answers a read on the following cycle and commits writes at the edge.
  always @(posedge clk) begin
    if (bus.mem_read) begin
      bus.mem_rdata <= {mem[bus.mem_addr], mem[8'(bus.mem_addr + 8'd1)],
                        mem[8'(bus.mem_addr + 8'd2)], mem[8'(bus.mem_addr + 8'd3)]};
    end
    if (bus.mem_write) begin
      mem[bus.mem_addr]               <= bus.mem_wdata[31:24];
      mem[8'(bus.mem_addr + 8'd1)]    <= bus.mem_wdata[23:16];
      mem[8'(bus.mem_addr + 8'd2)]    <= bus.mem_wdata[15:8];
      mem[8'(bus.mem_addr + 8'd3)]    <= bus.mem_wdata[7:0];
    end
  end

  always @(negedge clk) begin
    if (bus.mem_read) begin
      readCount = readCount + 1;
      lastRaddr = bus.mem_addr;
    end
    if (bus.mem_write) begin
      writeCount = writeCount + 1;
      lastWaddr  = bus.mem_addr;
      lastWdata  = bus.mem_wdata;
    end
    if (bus.mem_read && bus.mem_write) bothCount = bothCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount = assertCount + 1;
    if (observed !== expected) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; drives one request and waits (bounded) for done.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sext,
                               input logic [7:0] addr, input logic [31:0] wdata);
    readCount  = 0;
    writeCount = 0;
    bus.req    = 1'b1;
    bus.we     = we;
    bus.size   = size;
    bus.sext   = sext;
    bus.addr   = addr;
    bus.wdata  = wdata;
    lat        = 0;
    doneErr    = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bus.req = 1'b0;
      if (bus.done) begin
        lat     = c;
        doneErr = bus.err;
        break;
      end
    end
  endtask

  initial begin
    logic sawDone;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'h03; mem[8'h13] = 8'h04;
    mem[8'hFE] = 8'hDE; mem[8'hFF] = 8'hAD; mem[8'h00] = 8'hBE; mem[8'h01] = 8'hEF;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sext = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.mem_rdata = '0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset err", 32'(bus.err), 32'd0);
    checkOutput("reset strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    checkOutput("reset rdata", bus.rdata, 32'd0);
    checkOutput("reset mem_wdata", bus.mem_wdata, 32'd0);
    checkOutput("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;

    // Word store then word load at 0x04.
    applyStimulus(1'b1, 2'b10, 1'b0, 8'h04, 32'h11223344);
    checkOutput("word store latency", lat, 2);
    checkOutput("word store writes", writeCount, 1);
    checkOutput("word store reads", readCount, 0);
    checkOutput("word store wdata", lastWdata, 32'h11223344);
    checkOutput("word store addr", 32'(lastWaddr), 32'h04);
    checkOutput("word store err", 32'(doneErr), 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 8'h04, 32'h0);
    checkOutput("word load latency", lat, 3);
    checkOutput("word load reads", readCount, 1);
    checkOutput("word load rdata", bus.rdata, 32'h11223344);

    // Byte store read-modify-write at 0x05.
    applyStimulus(1'b1, 2'b00, 1'b0, 8'h05, 32'hFFFFFFAB);
    checkOutput("byte store latency", lat, 4);
    checkOutput("byte store reads", readCount, 1);
    checkOutput("byte store writes", writeCount, 1);
    checkOutput("byte store wdata", lastWdata, 32'hAB334400);
    checkOutput("byte store addr", 32'(lastWaddr), 32'h05);
    applyStimulus(1'b0, 2'b10, 1'b0, 8'h04, 32'h0);
    checkOutput("after byte store", bus.rdata, 32'h11AB3344);

    // Half store 0x8001 at 0x06, then extended sub-word loads.
    applyStimulus(1'b1, 2'b01, 1'b0, 8'h06, 32'h12348001);
    checkOutput("half store latency", lat, 4);
    checkOutput("half store wdata", lastWdata, 32'h80010000);
    applyStimulus(1'b0, 2'b01, 1'b1, 8'h06, 32'h0);
    checkOutput("half load sext", bus.rdata, 32'hFFFF8001);
    applyStimulus(1'b0, 2'b01, 1'b0, 8'h06, 32'h0);
    checkOutput("half load zext", bus.rdata, 32'h00008001);
    applyStimulus(1'b0, 2'b00, 1'b1, 8'h06, 32'h0);
    checkOutput("byte load sext", bus.rdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h07, 32'h0);
    checkOutput("byte load zext", bus.rdata, 32'h00000001);
    checkOutput("byte load latency", lat, 3);

    // Unaligned word load crossing the top of the address space.
    applyStimulus(1'b0, 2'b10, 1'b0, 8'hFE, 32'h0);
    checkOutput("wrap load reads", readCount, 1);
    checkOutput("wrap load addr", 32'(lastRaddr), 32'hFE);
    checkOutput("wrap load rdata", bus.rdata, 32'hDEADBEEF);

    // Illegal size, accepted straight out of the previous DONE.
    applyStimulus(1'b1, 2'b11, 1'b0, 8'h20, 32'h0);
    checkOutput("illegal latency", lat, 1);
    checkOutput("illegal err", 32'(doneErr), 32'd1);
    checkOutput("illegal strobes", readCount + writeCount, 0);
    @(negedge clk);
    checkOutput("err clears", 32'(bus.err), 32'd0);

    // Reset asserted while the byte store at 0x10 is in WR.
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sext = 1'b0;
    bus.addr = 8'h10; bus.wdata = 32'h00000055;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.req = 1'b0;
      if (bus.mem_write) begin
        lat = c;
        break;
      end
    end
    checkOutput("reach WR", lat, 3);
    rst = 1'b1;
    #1;
    checkOutput("rst drops write", 32'(bus.mem_write), 32'd0);
    checkOutput("rst drops busy", 32'(bus.busy), 32'd0);
    sawDone = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    rst = 1'b0;
    checkOutput("no done after rst", 32'(sawDone), 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    checkOutput("post rst latency", lat, 3);
    checkOutput("cancelled write", bus.rdata, 32'h01020304);

    checkOutput("read and write together", bothCount, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_W, default 8, byte-address width; SHALL match the banked data memory address width.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  1  CPU access request; sampled only when accepting (state IDLE or DONE).
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 sext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 addr  input  ADDR_W  byte address; any alignment.
REQ-009 wdata  input  32  store data, right-justified.
REQ-010 rdata  output  32  load result; holds until the next accepted load.
REQ-011 busy  output  1  high in every state except IDLE and DONE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  valid with done; 1 = illegal size.
REQ-014 mem_addr  output  ADDR_W  byte address to the banked data memory.
REQ-015 mem_wdata  output  32  write word, big-endian: byte at mem_addr in [31:24].
REQ-016 mem_read  output  1  memory read strobe.
REQ-017 mem_write  output  1  memory write strobe; writes all four bytes mem_addr..mem_addr+3.
REQ-018 mem_rdata  input  32  memory read word, big-endian; valid the cycle after mem_read with the same mem_addr.

Function
REQ-019 States SHALL be IDLE, RD, CAP, WR, DONE; all outputs SHALL be registered.
REQ-020 Acceptance: req=1 in IDLE or DONE SHALL latch we/size/sext/addr/wdata; req in RD/CAP/WR SHALL be ignored.
REQ-021 From acceptance: load -> RD; word store -> WR; byte/half store -> RD; size=11 -> DONE with err=1 and no memory strobe.
REQ-022 RD: mem_read=1, mem_addr=latched addr, next CAP.
REQ-023 CAP: sample mem_rdata at the end of the cycle; load -> DONE, sub-word store -> WR.
REQ-024 Load result, byte: mem_rdata[31:24] extended per sext; half: mem_rdata[31:16] extended; word: mem_rdata unchanged.
REQ-025 WR: mem_write=1, mem_addr=latched addr, next DONE.
REQ-026 WR data, word: wdata; byte: {wdata[7:0], captured[23:0]}; half: {wdata[15:0], captured[15:0]} (read-modify-write preserves the untouched bytes).
REQ-027 DONE: done=1 for exactly one cycle; then IDLE, or a new acceptance if req=1.
REQ-028 Latency from the acceptance edge to done: load 3 cycles, word store 2, sub-word store 4, illegal 1.
REQ-029 mem_read and mem_write SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per access.
REQ-030 Address wrap: an access at addr 0xFF, or any access crossing 0xFF, SHALL be passed unmodified; wrap is the memory's responsibility.
REQ-031 err=0 except in the DONE cycle of an illegal-size request.

Reset
REQ-032 rst=1 SHALL immediately force IDLE with busy, done, err, mem_read and mem_write at 0, and rdata, mem_addr and mem_wdata at 0, regardless of the current state.
REQ-033 A reset during WR SHALL cancel the write with no partial strobe after assertion; the interrupted access SHALL NOT produce done.
REQ-034 After deassertion, the first rising edge with req=1 SHALL be accepted.

Verification
REQ-035 Word store 0x11223344 at addr 0x04, then word load at 0x04 -> mem_write one cycle with mem_wdata=0x11223344, then rdata=0x11223344, done 3 cycles after the load is accepted.
REQ-036 Memory bytes 0x04..0x07 = 11 22 33 44; byte store 0xAB at 0x05 -> RD, CAP, WR sequence with mem_wdata=0xAB334400 (byte at 0x08 assumed 00), done after 4 cycles; bytes become 11 AB 33 44.
REQ-037 Memory word at 0x06 = 0x8001xxxx; half load with sext=1 -> rdata=0xFFFF8001; with sext=0 -> rdata=0x00008001.
REQ-038 Unaligned word load at 0xFE -> single mem_read at mem_addr=0xFE; rdata equals mem_rdata unchanged.
REQ-039 size=11 request -> done=1 with err=1 one cycle after acceptance, and mem_read and mem_write stay 0.
REQ-040 Assert rst during WR of a byte store -> mem_write drops within the same cycle, no done, state IDLE; a subsequent load completes normally.
